// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU command codes, status bit positions and FSM state encoding
package alu_arbiter_pkg;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester and response bus of alu_arbiter
//   requester side : req_valid/req_ready per requester, packed req_a/req_b/req_cmd/req_s
//                    (req_lock too when ALU_LOCK_EN is defined)
//   response side  : rsp_valid/rsp_ready handshake with rsp_id/rsp_result/rsp_status
//   modports       : master = requesters + consumer, slave = arbiter
interface alu_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*4-1:0]     req_cmd;
    logic [NREQ-1:0]       req_s;
`ifdef ALU_LOCK_EN
    logic [NREQ-1:0]       req_lock;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic [3:0]            rsp_status;
`ifdef ALU_LOCK_EN
    modport master (output req_valid, req_a, req_b, req_cmd, req_s, req_lock, rsp_ready,
                    input req_ready, rsp_valid, rsp_id, rsp_result, rsp_status);
    modport slave (input req_valid, req_a, req_b, req_cmd, req_s, req_lock, rsp_ready,
                   output req_ready, rsp_valid, rsp_id, rsp_result, rsp_status);
`else
    modport master (output req_valid, req_a, req_b, req_cmd, req_s, rsp_ready,
                    input req_ready, rsp_valid, rsp_id, rsp_result, rsp_status);
    modport slave (input req_valid, req_a, req_b, req_cmd, req_s, rsp_ready,
                   output req_ready, rsp_valid, rsp_id, rsp_result, rsp_status);
`endif
endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant among NREQ valid lines, pointer register inside
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_valid        : request lines
//   i_en           : grant allowed this cycle
//   i_hold         : on a grant, keep the pointer on the winner instead of advancing
//   o_grant/o_idx  : one-hot grant and its index (index valid whenever any request is seen)
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] i_valid,
    input  logic            i_en,
    input  logic            i_hold,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx
);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic          w_found;

    // first valid index at or after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_idx = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign o_grant = (i_en && w_found) ? (NREQ'(1) << w_idx) : '0;
    assign o_idx = w_idx;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_ptr <= '0;
        else if (|o_grant)
            r_ptr <= i_hold ? w_idx : ((w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1);
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 32-bit ALU between NREQ requesters, registers result/NZCV
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   io_bus          : requester + response bus (alu_arbiter_if.slave)
//   o_alu_a/b/cmd   : operands and command of the granted requester, zero when idle
//   o_alu_cin       : carry flag of the architectural status register
//   i_alu_result    : ALU result, i_alu_status : ALU {N,Z,C,V}
//   o_status_q      : architectural status register {N,Z,C,V}
//   i_flush         : drop the held response and block grants this cycle
//   ALU_LOCK_EN     : when defined, io_bus.req_lock pins round-robin priority on a requester
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    alu_arbiter_if.slave      io_bus,
    output logic [WIDTH-1:0]  o_alu_a,
    output logic [WIDTH-1:0]  o_alu_b,
    output logic [3:0]        o_alu_cmd,
    output logic              o_alu_cin,
    input  logic [WIDTH-1:0]  i_alu_result,
    input  logic [3:0]        i_alu_status,
    output logic [3:0]        o_status_q,
    input  logic              i_flush
);
    state_t           r_state;
    logic [IW-1:0]    r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_status;
    logic [3:0]       r_status;
    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_en;
    logic             w_xfer;
    logic             w_hold;

    // a new op may only enter when the response register is free or being drained
    assign w_en = (r_state == IDLE || io_bus.rsp_ready) && !i_flush;
`ifdef ALU_LOCK_EN
    assign w_hold = io_bus.req_lock[w_idx];
`else
    assign w_hold = 1'b0;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (io_bus.req_valid),
        .i_en    (w_en),
        .i_hold  (w_hold),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_xfer = |w_grant;
    assign io_bus.req_ready = w_grant;
    assign o_alu_a = w_xfer ? io_bus.req_a[w_idx*WIDTH +: WIDTH] : '0;
    assign o_alu_b = w_xfer ? io_bus.req_b[w_idx*WIDTH +: WIDTH] : '0;
    assign o_alu_cmd = w_xfer ? io_bus.req_cmd[w_idx*4 +: 4] : '0;
    assign o_alu_cin = r_status[ST_C];
    assign o_status_q = r_status;
    assign io_bus.rsp_valid = (r_state == BUSY);
    assign io_bus.rsp_id = r_rsp_id;
    assign io_bus.rsp_result = r_rsp_result;
    assign io_bus.rsp_status = r_rsp_status;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_rsp_id <= '0;
            r_rsp_result <= '0;
            r_rsp_status <= '0;
            r_status <= '0;
        end else if (w_xfer) begin
            r_state <= BUSY;
            r_rsp_id <= w_idx;
            r_rsp_result <= i_alu_result;
            r_rsp_status <= i_alu_status;
            if (io_bus.req_s[w_idx])
                r_status <= i_alu_status;
        end else if (i_flush || (r_state == BUSY && io_bus.rsp_ready)) begin
            r_state <= IDLE;
        end
    end
endmodule
